// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port, word-wide data memory.
// Sub-word stores become a two-cycle read-modify-write because the memory only writes whole words.
module dmem_arbiter #(
    parameter int ADDR_WIDTH     = 10,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_byte_address,
    input  logic [3:0]            a_wstrb,
    input  logic [31:0]           a_write_data,
    output logic                  a_ack,
    output logic [31:0]           a_read_data,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_byte_address,
    input  logic [3:0]            b_wstrb,
    input  logic [31:0]           b_write_data,
    output logic                  b_ack,
    output logic [31:0]           b_read_data,
    output logic [ADDR_WIDTH-1:0] mem_byte_address,
    output logic                  mem_write_enable,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);

    typedef enum logic [1:0] {IDLE, RMW, RESP} state_t;

    state_t                  state_reg, state_next;
    logic                    last_b_reg, last_b_next;
    logic                    grant_b_reg, grant_b_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [31:0]             merge_reg, merge_next;
    logic [31:0]             a_rd_reg, a_rd_next;
    logic [31:0]             b_rd_reg, b_rd_next;
    logic                    mem_we_int;

    logic                    sel_b;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [3:0]              sel_strb;
    logic [31:0]             sel_data;
    logic [31:0]             lane_mask;

    // B wins only when alone, or on a tie in round-robin mode when A was served last.
    assign sel_b    = b_req && (!a_req || (!FIXED_PRIORITY && !last_b_reg));
    assign sel_we   = sel_b ? b_we           : a_we;
    assign sel_addr = sel_b ? b_byte_address : a_byte_address;
    assign sel_strb = sel_b ? b_wstrb        : a_wstrb;
    assign sel_data = sel_b ? b_write_data   : a_write_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{sel_strb[gi]}};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            last_b_reg  <= 1'b1;
            grant_b_reg <= 1'b0;
            addr_reg    <= '0;
            merge_reg   <= '0;
            a_rd_reg    <= '0;
            b_rd_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            last_b_reg  <= last_b_next;
            grant_b_reg <= grant_b_next;
            addr_reg    <= addr_next;
            merge_reg   <= merge_next;
            a_rd_reg    <= a_rd_next;
            b_rd_reg    <= b_rd_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_b_next      = last_b_reg;
        grant_b_next     = grant_b_reg;
        addr_next        = addr_reg;
        merge_next       = merge_reg;
        a_rd_next        = a_rd_reg;
        b_rd_next        = b_rd_reg;
        mem_byte_address = '0;
        mem_we_int       = 1'b0;
        mem_write_data   = '0;
        a_ack            = 1'b0;
        b_ack            = 1'b0;
        case (state_reg)
            IDLE: begin
                if (a_req || b_req) begin
                    grant_b_next     = sel_b;
                    last_b_next      = sel_b;
                    mem_byte_address = sel_addr;
                    if (!sel_we) begin
                        if (sel_b) b_rd_next = mem_read_data;
                        else       a_rd_next = mem_read_data;
                        state_next = RESP;
                    end else if (sel_strb == 4'b1111) begin
                        mem_we_int     = 1'b1;
                        mem_write_data = sel_data;
                        state_next     = RESP;
                    end else if (sel_strb == 4'b0000) begin
                        state_next = RESP;
                    end else begin
                        addr_next  = sel_addr;
                        merge_next = (sel_data & lane_mask) | (mem_read_data & ~lane_mask);
                        state_next = RMW;
                    end
                end
            end
            RMW: begin
                mem_byte_address = addr_reg;
                mem_we_int       = 1'b1;
                mem_write_data   = merge_reg;
                state_next       = RESP;
            end
            RESP: begin
                a_ack      = !grant_b_reg;
                b_ack      = grant_b_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate with reset so a held full-word request cannot write while reset is low.
    assign mem_write_enable = mem_we_int & reset_n;
    assign a_read_data      = a_rd_reg;
    assign b_read_data      = b_rd_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed checks with literal values, then random traffic against a cycle-level model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [9:0]  a_byte_address = 0, b_byte_address = 0;
    logic [3:0]  a_wstrb = 0, b_wstrb = 0;
    logic [31:0] a_write_data = 0, b_write_data = 0;
    logic        a_ack, b_ack;
    logic [31:0] a_read_data, b_read_data;
    logic [9:0]  mem_byte_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data, mem_read_data;

    dmem_arbiter #(.ADDR_WIDTH(10), .FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_byte_address(a_byte_address), .a_wstrb(a_wstrb),
        .a_write_data(a_write_data), .a_ack(a_ack), .a_read_data(a_read_data),
        .b_req(b_req), .b_we(b_we), .b_byte_address(b_byte_address), .b_wstrb(b_wstrb),
        .b_write_data(b_write_data), .b_ack(b_ack), .b_read_data(b_read_data),
        .mem_byte_address(mem_byte_address), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Second instance in fixed-priority mode with a constant memory read value.
    logic        f_a_req = 0, f_b_req = 0;
    logic        f_a_ack, f_b_ack;
    logic [31:0] f_a_read_data, f_b_read_data;
    logic [9:0]  f_mem_addr;
    logic        f_mem_we;
    logic [31:0] f_mem_wdata;
    logic [31:0] f_mem_rdata = 32'hCAFE0001;

    dmem_arbiter #(.ADDR_WIDTH(10), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .a_req(f_a_req), .a_we(1'b0), .a_byte_address(10'h004), .a_wstrb(4'h0),
        .a_write_data(32'h0), .a_ack(f_a_ack), .a_read_data(f_a_read_data),
        .b_req(f_b_req), .b_we(1'b0), .b_byte_address(10'h008), .b_wstrb(4'h0),
        .b_write_data(32'h0), .b_ack(f_b_ack), .b_read_data(f_b_read_data),
        .mem_byte_address(f_mem_addr), .mem_write_enable(f_mem_we),
        .mem_write_data(f_mem_wdata), .mem_read_data(f_mem_rdata)
    );

    // Memory: combinational read, registered write, plus a preload path.
    logic [31:0] mem [256];
    logic        init_we = 0;
    logic [7:0]  init_idx = 0;
    logic [31:0] init_data = 0;
    assign mem_read_data = mem[mem_byte_address[9:2]];
    always @(posedge clk) begin
        if (init_we) mem[init_idx] <= init_data;
        else if (mem_write_enable) mem[mem_byte_address[9:2]] <= mem_write_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return (i == 3) ? 32'h11223344 : {b, b, b, b};
    endfunction

    // Reference model: schedules acks, the RMW write cycle and the next free grant cycle by cycle number.
    logic [31:0] ref_mem [256];
    int          t = 0, m_free = 0, m_rmw = -1, m_ack = -1;
    bit          m_ackb = 0, m_lastb = 1;
    logic [31:0] m_rda = 0, m_rdb = 0, m_rmwd = 0;
    logic [9:0]  m_rmwa = 0;

    always @(negedge clk) begin
        bit          gb;
        logic        we;
        logic [9:0]  ad;
        logic [3:0]  st;
        logic [31:0] dt, old;
        t++;
        if (!reset_n) begin
            if (init_we) ref_mem[init_idx] = init_data;
            chk("rst_outs", {29'd0, mem_write_enable, a_ack, b_ack}, 32'd0);
            chk("rst_a_rd", a_read_data, 32'd0);
            chk("rst_b_rd", b_read_data, 32'd0);
            m_free = t + 1; m_rmw = -1; m_ack = -1; m_lastb = 1; m_rda = 0; m_rdb = 0;
        end else begin
            chk("m_acks", {30'd0, a_ack, b_ack}, {30'd0, (m_ack == t) && !m_ackb, (m_ack == t) && m_ackb});
            chk("m_a_rd", a_read_data, m_rda);
            chk("m_b_rd", b_read_data, m_rdb);
            if (m_rmw == t) begin
                chk("m_rmw_we", {31'd0, mem_write_enable}, 32'd1);
                chk("m_rmw_addr", {22'd0, mem_byte_address}, {22'd0, m_rmwa});
                chk("m_rmw_data", mem_write_data, m_rmwd);
                ref_mem[m_rmwa[9:2]] = m_rmwd;
            end else if (t >= m_free && (a_req || b_req)) begin
                gb = b_req && (!a_req || !m_lastb);
                m_lastb = gb;
                we = gb ? b_we : a_we;
                ad = gb ? b_byte_address : a_byte_address;
                st = gb ? b_wstrb : a_wstrb;
                dt = gb ? b_write_data : a_write_data;
                old = ref_mem[ad[9:2]];
                chk("m_addr", {22'd0, mem_byte_address}, {22'd0, ad});
                m_ackb = gb; m_ack = t + 1; m_free = t + 2;
                if (!we) begin
                    chk("m_rd_we", {31'd0, mem_write_enable}, 32'd0);
                    if (gb) m_rdb = old; else m_rda = old;
                end else if (st == 4'hF) begin
                    chk("m_wr_we", {31'd0, mem_write_enable}, 32'd1);
                    chk("m_wr_data", mem_write_data, dt);
                    ref_mem[ad[9:2]] = dt;
                end else if (st == 4'h0) begin
                    chk("m_nop_we", {31'd0, mem_write_enable}, 32'd0);
                end else begin
                    chk("m_pw_we", {31'd0, mem_write_enable}, 32'd0);
                    for (int i = 0; i < 4; i++)
                        m_rmwd[8*i +: 8] = st[i] ? dt[8*i +: 8] : old[8*i +: 8];
                    m_rmwa = ad; m_rmw = t + 1; m_ack = t + 2; m_free = t + 3;
                end
            end else begin
                chk("m_idle_we", {31'd0, mem_write_enable}, 32'd0);
                if (t >= m_free) chk("m_idle_addr", {22'd0, mem_byte_address}, 32'd0);
            end
        end
    end

    task automatic drive(input bit pb, input bit rq, input bit we, input logic [9:0] ad,
                         input logic [3:0] st, input logic [31:0] dt);
        if (pb) begin b_req = rq; b_we = we; b_byte_address = ad; b_wstrb = st; b_write_data = dt; end
        else    begin a_req = rq; a_we = we; a_byte_address = ad; a_wstrb = st; a_write_data = dt; end
    endtask

    // One isolated access, issued right after a clock edge with the arbiter idle.
    task automatic access(input bit pb, input bit we, input logic [9:0] ad, input logic [3:0] st,
                          input logic [31:0] dt, output int lat, output int we_cnt, output int we_k,
                          output logic [31:0] wd, output logic [31:0] rd);
        drive(pb, 1, we, ad, st, dt);
        lat = -1; we_cnt = 0; we_k = -1; wd = 0;
        for (int k = 0; k < 8 && lat < 0; k++) begin
            @(negedge clk);
            if (mem_write_enable) begin we_cnt++; we_k = k; wd = mem_write_data; end
            if (pb ? b_ack : a_ack) lat = k;
        end
        @(posedge clk); #1;
        rd = pb ? b_read_data : a_read_data;
        drive(pb, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_access(input bit pb);
        logic [3:0] st;
        case ($urandom_range(0, 3))
            0:       st = 4'hF;
            1:       st = 4'h0;
            default: st = 4'($urandom);
        endcase
        drive(pb, 1, 1'($urandom), 10'($urandom), st, $urandom);
    endtask

    initial begin
        int          lat, wc, wk;
        logic [31:0] wd, rd;
        logic [15:0] pat;
        int          fa, fb, lat_b;
        bit          sa, sb;

        init_we = 1;
        for (int i = 0; i < 256; i++) begin
            init_idx = 8'(i); init_data = init_word(i);
            @(posedge clk); #1;
        end
        init_we = 0;
        chk("reset_state", {29'd0, mem_write_enable, a_ack, b_ack}, 32'd0);
        reset_n = 1;

        access(0, 0, 10'h00C, 4'h0, 0, lat, wc, wk, wd, rd);
        chk("rd_lat", lat, 1); chk("rd_data", rd, 32'h11223344); chk("rd_no_write", wc, 0);

        access(1, 1, 10'h010, 4'hF, 32'hDEADBEEF, lat, wc, wk, wd, rd);
        chk("fw_lat", lat, 1); chk("fw_we_at_G", wk, 0); chk("fw_we_cnt", wc, 1);
        access(0, 0, 10'h010, 4'h0, 0, lat, wc, wk, wd, rd);
        chk("fw_readback", rd, 32'hDEADBEEF);

        access(0, 1, 10'h00E, 4'hC, 32'hAABB0000, lat, wc, wk, wd, rd);
        chk("pw_lat", lat, 2); chk("pw_we_at_G1", wk, 1); chk("pw_we_cnt", wc, 1);
        chk("pw_merge", wd, 32'hAABB3344);
        access(0, 0, 10'h00C, 4'h0, 0, lat, wc, wk, wd, rd);
        chk("pw_readback", rd, 32'hAABB3344);

        access(1, 1, 10'h020, 4'h0, 32'h12345678, lat, wc, wk, wd, rd);
        chk("nop_lat", lat, 1); chk("nop_no_we", wc, 0);
        access(1, 0, 10'h020, 4'h0, 0, lat, wc, wk, wd, rd);
        chk("nop_unchanged", rd, 32'h08080808);

        // Last grant was B, so A takes the first tie, then strict alternation.
        drive(0, 1, 0, 10'h00C, 4'h0, 0);
        drive(1, 1, 0, 10'h010, 4'h0, 0);
        pat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pat = {pat[13:0], a_ack, b_ack};
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
        chk("rr_pattern", {16'd0, pat}, 32'h2121);

        f_a_req = 1; f_b_req = 1; fa = 0; fb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            fa += int'(f_a_ack); fb += int'(f_b_ack);
        end
        @(posedge clk); #1;
        f_a_req = 0;
        chk("fp_a_acks", fa, 4); chk("fp_b_acks", fb, 0);
        lat_b = -1;
        for (int k = 0; k < 6 && lat_b < 0; k++) begin
            @(negedge clk);
            if (f_b_ack) lat_b = k;
        end
        @(posedge clk); #1;
        f_b_req = 0;
        chk("fp_b_lat", lat_b, 1); chk("fp_b_rd", f_b_read_data, 32'hCAFE0001);

        drive(0, 1, 1, 10'h00C, 4'h3, 32'h00005566);
        @(posedge clk); #1;
        chk("rmw_we_before_rst", {31'd0, mem_write_enable}, 32'd1);
        chk("rmw_data_before_rst", mem_write_data, 32'hAABB5566);
        #1 reset_n = 0;
        #1;
        chk("rst_we_async", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_acks", {30'd0, a_ack, b_ack}, 32'd0);
        chk("rst_a_rd0", a_read_data, 32'd0);
        chk("rst_b_rd0", b_read_data, 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        access(0, 0, 10'h00C, 4'h0, 0, lat, wc, wk, wd, rd);
        chk("rst_dropped_rmw", rd, 32'hAABB3344);

        sa = 0; sb = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); sa = a_ack; sb = b_ack;
            @(posedge clk); #1;
            if (!a_req || sa) begin
                if ($urandom_range(0, 2) != 0) rand_access(0); else drive(0, 0, 0, 0, 0, 0);
            end
            if (!b_req || sb) begin
                if ($urandom_range(0, 2) != 0) rand_access(1); else drive(1, 0, 0, 0, 0, 0);
            end
        end
        for (int c = 0; c < 20 && (a_req || b_req); c++) begin
            @(negedge clk); sa = a_ack; sb = b_ack;
            @(posedge clk); #1;
            if (sa) drive(0, 0, 0, 0, 0, 0);
            if (sb) drive(1, 0, 0, 0, 0, 0);
        end
        chk("drain_done", {30'd0, a_req, b_req}, 32'd0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
